// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator. A clock-enable divider paces the
// raster so that each pixel lasts CLK_DIV system clocks. Column and row
// counters walk the raster in the order active, front porch, sync, back
// porch. A registered output stage decodes the counter state into
// coordinates, the visible flag, sync pulses and strobes. All outputs come
// from that one register stage, so they are mutually aligned and sit one
// clock behind the counters.
//
// Ports:
//   clock        system clock, all logic on the rising edge
//   reset        asynchronous, active-high reset
//   refresh      synchronous restart of the raster to (0,0)
//   pix_x        current column, 0..H_TOTAL-1
//   pix_y        current row, 0..V_TOTAL-1
//   visible      high inside the active picture area
//   hsync        horizontal sync, HS_POL while asserted
//   vsync        vertical sync, VS_POL while asserted
//   pix_ce       one-clock strobe on the first clock of each pixel
//   line_start   one-clock strobe on the first clock of column 0
//   frame_start  one-clock strobe on the first clock of pixel (0,0)
//   frame_count  completed frames, modulo 2^FC_W
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CLK_DIV  = 1,
  parameter int COL_W    = 12,
  parameter int ROW_W    = 11,
  parameter int FC_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             refresh,
  output logic [COL_W-1:0] pix_x,
  output logic [ROW_W-1:0] pix_y,
  output logic             visible,
  output logic             hsync,
  output logic             vsync,
  output logic             pix_ce,
  output logic             line_start,
  output logic             frame_start,
  output logic [FC_W-1:0]  frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // The divider needs at least one bit even when it never counts.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [COL_W-1:0] H_LAST       = COL_W'(H_TOTAL - 1);
  localparam logic [COL_W-1:0] H_ACT_END    = COL_W'(H_ACTIVE);
  localparam logic [COL_W-1:0] H_SYNC_START = COL_W'(H_ACTIVE + H_FP);
  localparam logic [COL_W-1:0] H_SYNC_END   = COL_W'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [ROW_W-1:0] V_LAST       = ROW_W'(V_TOTAL - 1);
  localparam logic [ROW_W-1:0] V_ACT_END    = ROW_W'(V_ACTIVE);
  localparam logic [ROW_W-1:0] V_SYNC_START = ROW_W'(V_ACTIVE + V_FP);
  localparam logic [ROW_W-1:0] V_SYNC_END   = ROW_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic [COL_W-1:0] h_cnt;
  logic [ROW_W-1:0] v_cnt;
  logic [FC_W-1:0]  fc_cnt;

  logic tick;
  logic line_end;
  logic frame_end;

  // tick marks the last system clock of a pixel; the raster moves on it.
  assign tick      = (div_cnt == DIV_LAST);
  assign line_end  = tick && (h_cnt == H_LAST);
  assign frame_end = line_end && (v_cnt == V_LAST);

  // Pixel-clock divider. With CLK_DIV=1 it stays at zero and tick is
  // permanently high. refresh realigns it so the restarted raster begins on
  // a fresh pixel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (refresh) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Column counter, advancing once per pixel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
    end else if (refresh) begin
      h_cnt <= '0;
    end else if (tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
      end else begin
        h_cnt <= h_cnt + COL_W'(1);
      end
    end
  end

  // Row counter, advancing on the last pixel of each line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v_cnt <= '0;
    end else if (refresh) begin
      v_cnt <= '0;
    end else if (line_end) begin
      if (v_cnt == V_LAST) begin
        v_cnt <= '0;
      end else begin
        v_cnt <= v_cnt + ROW_W'(1);
      end
    end
  end

  // Completed-frame counter. A frame cut short by refresh on its final
  // wrap tick did not complete, so refresh suppresses the increment.
  // refresh does not clear the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fc_cnt <= '0;
    end else if (!refresh && frame_end) begin
      fc_cnt <= fc_cnt + FC_W'(1);
    end
  end

  logic vis_d;
  logic hs_d;
  logic vs_d;
  logic ce_d;
  logic ls_d;
  logic fs_d;

  // Decode of the current counter state feeding the output register.
  // vsync depends only on the row, so it switches together with column 0.
  always_comb begin
    vis_d = 1'b0;
    hs_d  = ~HS_POL;
    vs_d  = ~VS_POL;
    ce_d  = 1'b0;
    ls_d  = 1'b0;
    fs_d  = 1'b0;

    vis_d = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);

    if ((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END)) begin
      hs_d = HS_POL;
    end

    if ((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END)) begin
      vs_d = VS_POL;
    end

    ce_d = (div_cnt == '0);
    ls_d = ce_d && (h_cnt == '0);
    fs_d = ls_d && (v_cnt == '0);
  end

  // Output stage. frame_count is registered here as well, so the new count
  // appears on the same clock as the frame_start of the frame that follows.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_x       <= '0;
      pix_y       <= '0;
      visible     <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      pix_ce      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      pix_x       <= h_cnt;
      pix_y       <= v_cnt;
      visible     <= vis_d;
      hsync       <= hs_d;
      vsync       <= vs_d;
      pix_ce      <= ce_d;
      line_start  <= ls_d;
      frame_start <= fs_d;
      frame_count <= fc_cnt;
    end
  end

endmodule
